// File: rtl/pop_mode_sequencer_if.sv
// Bus between the POP mode sequencer and its surroundings: raw buttons,
// timer channels and per-mode configuration in; channel, LED, mode and
// button status out. The sequencer uses the slave modport.
interface pop_mode_sequencer_if #(
  parameter int NUM_MODES = 4,
  parameter int NUM_CH    = 4,
  parameter int NUM_BTN   = 6
);
  localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

  logic [NUM_BTN-1:0]          btn_n;
  logic [NUM_CH-1:0]           timer_ch;
  logic [NUM_MODES*NUM_CH-1:0] mode_pattern;
  logic [NUM_MODES*2-1:0]      led_cfg;

  logic [NUM_CH-1:0]           ch_out;
  logic                        led_out;
  logic [MODE_W-1:0]           mode;
  logic                        mode_change;
  logic [NUM_BTN-1:0]          btn_press;
  logic [NUM_BTN-1:0]          btn_level;

  modport master (
    output btn_n, timer_ch, mode_pattern, led_cfg,
    input  ch_out, led_out, mode, mode_change, btn_press, btn_level
  );

  modport slave (
    input  btn_n, timer_ch, mode_pattern, led_cfg,
    output ch_out, led_out, mode, mode_change, btn_press, btn_level
  );
endinterface

// File: rtl/pop_mode_sequencer.sv
// POP timing board front-panel / mode controller.
// Debounces active-low buttons, steps a mode counter on button 0, drives the
// output channels from per-mode static patterns or from the timer channels
// (one timer-driven mode), blanks all channels for a fixed time after every
// mode change, and drives a status LED whose style is chosen per mode.
// Optional build macro BTN_AUTOREPEAT_EN: buttons 1..NUM_BTN-1 emit repeated
// press pulses while held; without it no repeat logic exists.
module pop_mode_sequencer #(
  parameter int NUM_MODES        = 4,
  parameter int NUM_CH           = 4,
  parameter int NUM_BTN          = 6,
  parameter int TIMER_MODE       = 1,
  parameter int DEBOUNCE_DIV     = 256,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int SLOW_LOG2        = 21,
  parameter int FAST_LOG2        = 18,
  parameter int BLANK_CYCLES     = 16
) (
  input logic                clk,
  input logic                reset,
  pop_mode_sequencer_if.slave bus
);

  localparam int MODE_W  = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int PRE_W   = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam int DCNT_W  = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam int BLINK_W = (SLOW_LOG2 > FAST_LOG2) ? SLOW_LOG2 : FAST_LOG2;

  localparam logic [MODE_W-1:0]  LAST_MODE   = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0]  TIMER_IDX   = MODE_W'(TIMER_MODE);
  localparam bit                 HAS_TIMER   = (TIMER_MODE < NUM_MODES);
  localparam logic [PRE_W-1:0]   PRE_LAST    = PRE_W'(DEBOUNCE_DIV - 1);
  localparam logic [DCNT_W-1:0]  DCNT_LAST   = DCNT_W'(DEBOUNCE_SAMPLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_INIT  = BLANK_W'(BLANK_CYCLES);

  // Per-mode views of the flattened configuration buses
  logic [NUM_CH-1:0] pattern_arr [NUM_MODES];
  logic [1:0]        led_arr     [NUM_MODES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MODES; gi++) begin : g_mode_slice
      assign pattern_arr[gi] = bus.mode_pattern[gi*NUM_CH +: NUM_CH];
      assign led_arr[gi]     = bus.led_cfg[gi*2 +: 2];
    end
  endgenerate

  // Button path state
  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  logic [NUM_BTN-1:0] stable_q, stable_d;
  logic [NUM_BTN-1:0] stable_dly_q, stable_dly_d;
  logic [NUM_BTN-1:0] btn_press_q, btn_press_d;
  logic [DCNT_W-1:0]  deb_cnt_q [NUM_BTN];
  logic [DCNT_W-1:0]  deb_cnt_d [NUM_BTN];
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic               tick;
  logic [NUM_BTN-1:0] rise;

  // Mode / output state
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic               mode_change_q, mode_change_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [NUM_CH-1:0]  ch_out_q, ch_out_d;
  logic               led_out_q, led_out_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               is_timer_mode;

  // Synchroniser, sample-tick prescaler and per-button debounce counters
  always_comb begin
    sync1_d      = ~bus.btn_n;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    presc_d      = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
    tick         = (presc_q == PRE_LAST);
    for (int i = 0; i < NUM_BTN; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (tick) begin
        if (sync2_q[i] != stable_q[i]) begin
          // Enough consecutive disagreeing samples: accept the new level
          if (deb_cnt_q[i] == DCNT_LAST) begin
            stable_d[i]  = ~stable_q[i];
            deb_cnt_d[i] = '0;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
          end
        end else begin
          deb_cnt_d[i] = '0;
        end
      end
    end
  end

  assign rise = stable_q & ~stable_dly_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int               RPT_W      = FAST_LOG2 + 1;
  localparam logic [RPT_W-1:0] RPT_HOLD   = RPT_W'(2**FAST_LOG2);
  // After a repeat the timer restarts so the next one lands one repeat
  // period later instead of a full hold time later.
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(2**FAST_LOG2 - 2**(FAST_LOG2-2) + 1);

  logic [RPT_W-1:0]   rpt_q [NUM_BTN];
  logic [RPT_W-1:0]   rpt_d [NUM_BTN];
  logic [NUM_BTN-1:0] rpt_fire;

  // Hold timers for the repeating buttons; button 0 never repeats
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rpt_d[i] = '0;
      if (i != 0 && stable_q[i]) begin
        if (rpt_q[i] == RPT_HOLD) begin
          rpt_fire[i] = 1'b1;
          rpt_d[i]    = RPT_RELOAD;
        end else begin
          rpt_d[i] = rpt_q[i] + 1'b1;
        end
      end
    end
  end

  // Hold timer registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BTN; i++) begin
      if (reset) rpt_q[i] <= '0;
      else       rpt_q[i] <= rpt_d[i];
    end
  end

  // Press pulse on each debounced press, plus repeats while held
  always_comb begin
    btn_press_d = rise | rpt_fire;
  end
`else
  // Press pulse once per debounced press; releases never pulse
  always_comb begin
    btn_press_d = rise;
  end
`endif

  // Button path registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      btn_press_q  <= '0;
      presc_q      <= '0;
      for (int i = 0; i < NUM_BTN; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      btn_press_q  <= btn_press_d;
      presc_q      <= presc_d;
      for (int i = 0; i < NUM_BTN; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // Mode stepping on button 0 and blanking counter (reloaded on every step)
  always_comb begin
    mode_d        = mode_q;
    mode_change_d = 1'b0;
    blank_d       = blank_q;
    if (btn_press_q[0]) begin
      mode_d        = (mode_q == LAST_MODE) ? '0 : mode_q + 1'b1;
      mode_change_d = 1'b1;
      blank_d       = BLANK_INIT;
    end else if (blank_q != '0) begin
      blank_d = blank_q - 1'b1;
    end
  end

  assign is_timer_mode = HAS_TIMER && (mode_d == TIMER_IDX);

  // Channel and LED next values; channels use the next mode/blank state so
  // the old pattern never shows for a cycle after a mode change
  always_comb begin
    ch_out_d = '0;
    if (blank_d == '0) begin
      if (is_timer_mode) ch_out_d = bus.timer_ch;
      else               ch_out_d = pattern_arr[mode_d];
    end
    blink_d   = blink_q + 1'b1;
    led_out_d = 1'b0;
    case (led_arr[mode_q])
      2'b00:   led_out_d = 1'b0;
      2'b01:   led_out_d = 1'b1;
      2'b10:   led_out_d = blink_q[SLOW_LOG2-1];
      default: led_out_d = blink_q[FAST_LOG2-1];
    endcase
  end

  // Mode, blanking, output and blink registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q        <= '0;
      mode_change_q <= 1'b0;
      blank_q       <= '0;
      ch_out_q      <= '0;
      led_out_q     <= 1'b0;
      blink_q       <= '0;
    end else begin
      mode_q        <= mode_d;
      mode_change_q <= mode_change_d;
      blank_q       <= blank_d;
      ch_out_q      <= ch_out_d;
      led_out_q     <= led_out_d;
      blink_q       <= blink_d;
    end
  end

  assign bus.ch_out      = ch_out_q;
  assign bus.led_out     = led_out_q;
  assign bus.mode        = mode_q;
  assign bus.mode_change = mode_change_q;
  assign bus.btn_press   = btn_press_q;
  assign bus.btn_level   = stable_q;

endmodule

// File: tb/tb_pop_mode_sequencer.sv
// Directed bench for pop_mode_sequencer with small timing parameters.
// A second instance with a long blanking time lets a second mode press land
// inside the blanking window.
module tb_pop_mode_sequencer;
  localparam int NM = 4;
  localparam int NC = 4;
  localparam int NB = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pop_mode_sequencer_if #(.NUM_MODES(NM), .NUM_CH(NC), .NUM_BTN(NB)) bus ();
  pop_mode_sequencer_if #(.NUM_MODES(NM), .NUM_CH(NC), .NUM_BTN(NB)) bus_lb ();

  assign bus_lb.btn_n        = bus.btn_n;
  assign bus_lb.timer_ch     = bus.timer_ch;
  assign bus_lb.mode_pattern = bus.mode_pattern;
  assign bus_lb.led_cfg      = bus.led_cfg;

  pop_mode_sequencer #(
    .NUM_MODES(NM), .NUM_CH(NC), .NUM_BTN(NB), .TIMER_MODE(1),
    .DEBOUNCE_DIV(4), .DEBOUNCE_SAMPLES(3), .SLOW_LOG2(5), .FAST_LOG2(6),
    .BLANK_CYCLES(5)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  pop_mode_sequencer #(
    .NUM_MODES(NM), .NUM_CH(NC), .NUM_BTN(NB), .TIMER_MODE(1),
    .DEBOUNCE_DIV(4), .DEBOUNCE_SAMPLES(3), .SLOW_LOG2(5), .FAST_LOG2(6),
    .BLANK_CYCLES(64)
  ) u_dut_lb (
    .clk(clk), .reset(reset), .bus(bus_lb)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic wait_press(input int idx, input int limit, output int cyc);
    cyc = -1;
    for (int n = 1; n <= limit; n++) begin
      step();
      if (bus.btn_press[idx]) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic release_count(input int idx, input int n, output int pulses);
    pulses = 0;
    bus.btn_n[idx] = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      if (bus.btn_press[idx]) pulses++;
    end
  endtask

  task automatic test_reset();
    int early;
    int pulses;
    bus.btn_n = '0;
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.ch_out !== 0 || bus.led_out !== 0 || bus.mode !== 0 || bus.btn_level !== 0 ||
        bus.btn_press !== 0 || bus.mode_change !== 0) begin
      errors++;
      $display("FAIL reset_outputs: ch=%h led=%b mode=%0d lvl=%h press=%h mc=%b required all 0",
               bus.ch_out, bus.led_out, bus.mode, bus.btn_level, bus.btn_press, bus.mode_change);
    end
    reset = 1'b0;
    early = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (bus.btn_press != 0) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL reset_no_early_press: got %0d pulse cycles required 0", early);
    end
    checks++;
    if (bus.btn_level !== 6'h3F) begin
      errors++;
      $display("FAIL reset_level_edge12: got %h required 3f", bus.btn_level);
    end
    step();
    checks++;
    if (bus.btn_press !== 6'h3F) begin
      errors++;
      $display("FAIL reset_press_edge13: got %h required 3f", bus.btn_press);
    end
    step();
    checks++;
    if (bus.mode !== 1 || bus.mode_change !== 1'b1 || bus.btn_press !== 0 || bus.ch_out !== 0) begin
      errors++;
      $display("FAIL first_mode_step: mode=%0d mc=%b press=%h ch=%h required 1 1 00 0",
               bus.mode, bus.mode_change, bus.btn_press, bus.ch_out);
    end
    repeat (4) step();
    checks++;
    if (bus.ch_out !== 4'h0 || bus.mode_change !== 1'b0) begin
      errors++;
      $display("FAIL blank_last_cycle: ch=%h mc=%b required 0 0", bus.ch_out, bus.mode_change);
    end
    step();
    checks++;
    if (bus.ch_out !== 4'hA) begin
      errors++;
      $display("FAIL timer_follow: ch=%h required a", bus.ch_out);
    end
    bus.timer_ch = 4'h5;
    checks++;
    if (bus.ch_out !== 4'hA) begin
      errors++;
      $display("FAIL timer_lag_hold: ch=%h required a", bus.ch_out);
    end
    step();
    checks++;
    if (bus.ch_out !== 4'h5) begin
      errors++;
      $display("FAIL timer_lag_update: ch=%h required 5", bus.ch_out);
    end
    bus.btn_n = '1;
    pulses = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (bus.btn_press != 0) pulses++;
    end
    checks++;
    if (pulses !== 0 || bus.btn_level !== 0 || bus.mode !== 1) begin
      errors++;
      $display("FAIL release_no_pulse: pulses=%0d lvl=%h mode=%0d required 0 00 1",
               pulses, bus.btn_level, bus.mode);
    end
    $display("test_reset done");
  endtask

  task automatic test_mode_press();
    int c;
    int v;
    int p;
    bus.btn_n[0] = 1'b0;
    wait_press(0, 40, c);
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL mode_press_timeout: waited %0d required a pulse", c);
    end
    step();
    checks++;
    if (bus.mode !== 2 || bus.mode_change !== 1'b1 || bus.ch_out !== 0) begin
      errors++;
      $display("FAIL mode_press_step: mode=%0d mc=%b ch=%h required 2 1 0",
               bus.mode, bus.mode_change, bus.ch_out);
    end
    v = 0;
    repeat (4) begin
      step();
      if (bus.ch_out != 0 || bus.mode_change != 0) v++;
    end
    checks++;
    if (v !== 0) begin
      errors++;
      $display("FAIL mode_press_blank: %0d bad cycles required 0", v);
    end
    step();
    checks++;
    if (bus.ch_out !== 4'hC) begin
      errors++;
      $display("FAIL mode2_pattern: ch=%h required c", bus.ch_out);
    end
    release_count(0, 24, p);
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL mode_press_release: pulses=%0d required 0", p);
    end
    $display("test_mode_press done mode=%0d", bus.mode);
  endtask

  task automatic test_bounce();
    int p;
    int c;
    p = 0;
    for (int k = 0; k < 60; k++) begin
      bus.btn_n[2] = ((k / 5) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      if (bus.btn_press[2]) p++;
    end
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL bounce_no_press: pulses=%0d required 0", p);
    end
    bus.btn_n[2] = 1'b0;
    wait_press(2, 40, c);
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL bounce_hold_press: waited %0d required a pulse", c);
    end
    p = 0;
    repeat (30) begin
      step();
      if (bus.btn_press[2]) p++;
    end
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL bounce_single_pulse: extra=%0d required 0", p);
    end
    release_count(2, 24, p);
    checks++;
    if (p !== 0 || bus.mode !== 2) begin
      errors++;
      $display("FAIL bounce_release: pulses=%0d mode=%0d required 0 2", p, bus.mode);
    end
    $display("test_bounce done");
  endtask

  task automatic test_wrap();
    int c;
    int p;
    int exp_mode [4] = '{1, 2, 3, 0};
    logic [3:0] exp_ch [4] = '{4'hA, 4'hC, 4'h9, 4'h3};
    bus.btn_n = '1;
    bus.timer_ch = 4'hA;
    apply_reset(2);
    for (int k = 0; k < 4; k++) begin
      bus.btn_n[0] = 1'b0;
      wait_press(0, 40, c);
      release_count(0, 24, p);
      checks++;
      if (c < 0 || bus.mode !== exp_mode[k] || bus.ch_out !== exp_ch[k]) begin
        errors++;
        $display("FAIL wrap_step%0d: wait=%0d mode=%0d ch=%h required mode=%0d ch=%h",
                 k, c, bus.mode, bus.ch_out, exp_mode[k], exp_ch[k]);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_blank_reload();
    int c;
    int v;
    int got;
    int p;
    bus.btn_n = '1;
    bus.timer_ch = 4'hA;
    apply_reset(2);
    bus.btn_n[0] = 1'b0;
    wait_press(0, 40, c);
    step();
    checks++;
    if (c < 0 || bus_lb.mode !== 1 || bus_lb.ch_out !== 0) begin
      errors++;
      $display("FAIL reload_first: wait=%0d mode=%0d ch=%h required mode=1 ch=0",
               c, bus_lb.mode, bus_lb.ch_out);
    end
    v = 0;
    bus.btn_n[0] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus_lb.ch_out != 0) v++;
      if (!bus.btn_level[0]) break;
    end
    bus.btn_n[0] = 1'b0;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus_lb.ch_out != 0) v++;
      if (bus.btn_press[0]) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (got !== 1) begin
      errors++;
      $display("FAIL reload_second_press: got=%0d required 1", got);
    end
    step();
    checks++;
    if (bus_lb.mode !== 2 || bus_lb.mode_change !== 1'b1) begin
      errors++;
      $display("FAIL reload_mode: mode=%0d mc=%b required 2 1", bus_lb.mode, bus_lb.mode_change);
    end
    repeat (63) begin
      step();
      if (bus_lb.ch_out != 0) v++;
    end
    checks++;
    if (v !== 0) begin
      errors++;
      $display("FAIL reload_blanking: %0d nonzero cycles required 0", v);
    end
    step();
    checks++;
    if (bus_lb.ch_out !== 4'hC) begin
      errors++;
      $display("FAIL reload_after_blank: ch=%h required c", bus_lb.ch_out);
    end
    release_count(0, 24, p);
    $display("test_blank_reload done");
  endtask

  task automatic test_led();
    int v;
    bus.btn_n = '1;
    bus.led_cfg = 8'h02;
    apply_reset(2);
    v = 0;
    for (int n = 1; n <= 65; n++) begin
      step();
      if (n == 16) begin
        checks++;
        if (bus.led_out !== 1'b0) begin
          errors++;
          $display("FAIL led_slow_e16: got %b required 0", bus.led_out);
        end
      end
      if (n == 17) begin
        checks++;
        if (bus.led_out !== 1'b1) begin
          errors++;
          $display("FAIL led_slow_e17: got %b required 1", bus.led_out);
        end
      end
      if (n == 32) begin
        checks++;
        if (bus.led_out !== 1'b1) begin
          errors++;
          $display("FAIL led_slow_e32: got %b required 1", bus.led_out);
        end
      end
      if (n == 33) begin
        checks++;
        if (bus.led_out !== 1'b0) begin
          errors++;
          $display("FAIL led_slow_e33: got %b required 0", bus.led_out);
        end
        bus.led_cfg = 8'h01;
      end
      if (n >= 34 && n <= 40 && bus.led_out !== 1'b1) v++;
      if (n == 40) bus.led_cfg = 8'h03;
      if (n == 41) begin
        checks++;
        if (v !== 0 || bus.led_out !== 1'b1) begin
          errors++;
          $display("FAIL led_on_fast41: off_cycles=%0d led=%b required 0 1", v, bus.led_out);
        end
      end
      if (n == 64) begin
        checks++;
        if (bus.led_out !== 1'b1) begin
          errors++;
          $display("FAIL led_fast_e64: got %b required 1", bus.led_out);
        end
      end
      if (n == 65) begin
        checks++;
        if (bus.led_out !== 1'b0) begin
          errors++;
          $display("FAIL led_fast_e65: got %b required 0", bus.led_out);
        end
      end
    end
    bus.led_cfg = 8'h00;
    step();
    step();
    checks++;
    if (bus.led_out !== 1'b0) begin
      errors++;
      $display("FAIL led_off: got %b required 0", bus.led_out);
    end
    $display("test_led done");
  endtask

  task automatic test_hold();
    int c;
    int p;
    bus.btn_n = '1;
    apply_reset(2);
    bus.btn_n[1] = 1'b0;
    wait_press(1, 40, c);
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL hold_first_press: waited %0d required a pulse", c);
    end
`ifdef BTN_AUTOREPEAT_EN
    wait_press(1, 100, c);
    checks++;
    if (c !== 64) begin
      errors++;
      $display("FAIL hold_first_repeat: gap=%0d required 64", c);
    end
    wait_press(1, 40, c);
    checks++;
    if (c !== 16) begin
      errors++;
      $display("FAIL hold_next_repeat: gap=%0d required 16", c);
    end
`else
    p = 0;
    repeat (100) begin
      step();
      if (bus.btn_press[1]) p++;
    end
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL hold_no_repeat: pulses=%0d required 0", p);
    end
`endif
    release_count(1, 24, p);
    checks++;
    if (p !== 0 || bus.mode !== 0) begin
      errors++;
      $display("FAIL hold_release: pulses=%0d mode=%0d required 0 0", p, bus.mode);
    end
    $display("test_hold done");
  endtask

  task automatic test_reset_midway();
    int early;
    int p;
    bus.btn_n = '1;
    bus.btn_n[0] = 1'b0;
    repeat (9) step();
    apply_reset(1);
    early = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (bus.btn_press[0]) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL midway_discard: early pulses=%0d required 0", early);
    end
    step();
    checks++;
    if (bus.btn_press[0] !== 1'b1) begin
      errors++;
      $display("FAIL midway_press_e13: got %b required 1", bus.btn_press[0]);
    end
    release_count(0, 24, p);
    $display("test_reset_midway done");
  endtask

  initial begin
    bus.btn_n        = '1;
    bus.timer_ch     = 4'hA;
    bus.mode_pattern = 16'h9C63;
    bus.led_cfg      = 8'h02;
    test_reset();
    test_mode_press();
    test_bounce();
    test_wrap();
    test_blank_reload();
    test_led();
    test_hold();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
